// File: rtl/cache_axi_arbiter.sv
// Shares one AXI4 master port between icache line refills, dcache line refills and dcache write-backs.
// Reads and writes run as two independent FSMs so a write-back can overlap an icache refill.
//
// Ports:
//   clk, rst                          clock; synchronous active-low reset
//   inst_ren_i/inst_araddr_i          icache refill request (level) and miss address
//   inst_rvalid_o/inst_rdata_o        icache refill done pulse and line
//   data_ren_i/data_araddr_i          dcache refill request (level) and miss address
//   data_rvalid_o/data_rdata_o        dcache refill done pulse and line
//   data_wen_i/data_awaddr_i/_wdata_i dcache write-back request, address and line
//   data_bvalid_o                     write-back done pulse
//   axi_ar*/axi_r*                    AXI read address and read data channels
//   axi_aw*/axi_w*/axi_b*             AXI write address, write data and response channels
module cache_axi_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int STARVE_MAX = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_ren_i,
    input  logic [31:0]              inst_araddr_i,
    output logic                     inst_rvalid_o,
    output logic [LINE_WORDS*32-1:0] inst_rdata_o,
    input  logic                     data_ren_i,
    input  logic [31:0]              data_araddr_i,
    output logic                     data_rvalid_o,
    output logic [LINE_WORDS*32-1:0] data_rdata_o,
    input  logic                     data_wen_i,
    input  logic [31:0]              data_awaddr_i,
    input  logic [LINE_WORDS*32-1:0] data_wdata_i,
    output logic                     data_bvalid_o,
    output logic                     axi_arvalid_o,
    output logic [31:0]              axi_araddr_o,
    output logic [7:0]               axi_arlen_o,
    input  logic                     axi_arready_i,
    input  logic                     axi_rvalid_i,
    input  logic [31:0]              axi_rdata_i,
    input  logic                     axi_rlast_i,
    output logic                     axi_rready_o,
    output logic                     axi_awvalid_o,
    output logic [31:0]              axi_awaddr_o,
    output logic [7:0]               axi_awlen_o,
    input  logic                     axi_awready_i,
    output logic                     axi_wvalid_o,
    output logic [31:0]              axi_wdata_o,
    output logic                     axi_wlast_o,
    output logic [3:0]               axi_wstrb_o,
    input  logic                     axi_wready_i,
    input  logic                     axi_bvalid_i,
    output logic                     axi_bready_o
);

    localparam int LW = LINE_WORDS * 32;
    localparam int BW = $clog2(LINE_WORDS);
    localparam int OB = BW + 2;
    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    rstate_t r_rstate, w_rstate_nxt;
    wstate_t r_wstate, w_wstate_nxt;

    logic          r_rgnt_d;
    logic [31:0]   r_raddr;
    logic [BW-1:0] r_rbeat;
    logic [SW-1:0] r_starve;
    logic [LW-1:0] r_inst_rdata;
    logic [LW-1:0] r_data_rdata;
    logic          r_inst_rvalid;
    logic          r_data_rvalid;
    logic [31:0]   r_waddr;
    logic [LW-1:0] r_wbuf;
    logic [BW-1:0] r_wbeat;
    logic          r_bvalid;

    logic [31:0] w_i_line, w_d_line, w_aw_line;
    logic w_raw, w_rhold, w_i_elig, w_d_elig, w_i_win;
    logic w_rgrant, w_rbeat_en, w_rdone;
    logic w_wstart, w_wbeat_en, w_bdone;
    logic w_unused;

    assign w_i_line  = {inst_araddr_i[31:OB], {OB{1'b0}}};
    assign w_d_line  = {data_araddr_i[31:OB], {OB{1'b0}}};
    assign w_aw_line = {data_awaddr_i[31:OB], {OB{1'b0}}};
    assign w_unused  = ^{axi_rlast_i, inst_araddr_i[OB-1:0],
                         data_araddr_i[OB-1:0], data_awaddr_i[OB-1:0]};

    // A dcache read of the line being written back would fetch stale memory.
    assign w_raw    = (r_wstate != W_IDLE) && (w_d_line == r_waddr);
    // No grant while a done pulse is out: the requester still shows the old request.
    assign w_rhold  = r_inst_rvalid | r_data_rvalid;
    assign w_i_elig = inst_ren_i && !w_rhold;
    assign w_d_elig = data_ren_i && !w_rhold && !w_raw;
    assign w_i_win  = w_i_elig && (!w_d_elig || r_starve >= SMAX);

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_rgrant      = 1'b0;
        w_rbeat_en    = 1'b0;
        w_rdone       = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (w_i_elig || w_d_elig) begin
                    w_rgrant     = 1'b1;
                    w_rstate_nxt = R_AR;
                end
            end
            R_AR: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                axi_rready_o = 1'b1;
                if (axi_rvalid_i) begin
                    w_rbeat_en = 1'b1;
                    if (r_rbeat == LAST) begin
                        w_rdone      = 1'b1;
                        w_rstate_nxt = R_IDLE;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_wstart      = 1'b0;
        w_wbeat_en    = 1'b0;
        w_bdone       = 1'b0;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_wlast_o   = 1'b0;
        axi_bready_o  = 1'b0;
        unique case (r_wstate)
            W_IDLE: begin
                if (data_wen_i && !r_bvalid) begin
                    w_wstart     = 1'b1;
                    w_wstate_nxt = W_AW;
                end
            end
            W_AW: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                axi_wvalid_o = 1'b1;
                axi_wlast_o  = (r_wbeat == LAST);
                if (axi_wready_i) begin
                    w_wbeat_en = 1'b1;
                    if (r_wbeat == LAST) w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    w_bdone      = 1'b1;
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rgnt_d      <= 1'b0;
            r_raddr       <= '0;
            r_rbeat       <= '0;
            r_starve      <= '0;
            r_inst_rdata  <= '0;
            r_data_rdata  <= '0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
        end else begin
            r_inst_rvalid <= w_rdone && !r_rgnt_d;
            r_data_rvalid <= w_rdone && r_rgnt_d;
            // Counts dcache grants taken while the icache is kept waiting.
            if (!inst_ren_i) begin
                r_starve <= '0;
            end else if (w_rgrant) begin
                if (w_i_win) r_starve <= '0;
                else if (r_starve < SMAX) r_starve <= r_starve + SW'(1);
            end
            if (w_rgrant) begin
                r_rgnt_d <= !w_i_win;
                r_raddr  <= w_i_win ? w_i_line : w_d_line;
            end
            // Beat counter wraps to 0 after the last word (power-of-two line).
            if (w_rbeat_en) begin
                r_rbeat <= r_rbeat + BW'(1);
                if (r_rgnt_d) r_data_rdata[{r_rbeat, 5'b0} +: 32] <= axi_rdata_i;
                else          r_inst_rdata[{r_rbeat, 5'b0} +: 32] <= axi_rdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_waddr  <= '0;
            r_wbuf   <= '0;
            r_wbeat  <= '0;
            r_bvalid <= 1'b0;
        end else begin
            r_bvalid <= w_bdone;
            if (w_wstart) begin
                r_waddr <= w_aw_line;
                r_wbuf  <= data_wdata_i;
            end
            if (w_wbeat_en) r_wbeat <= r_wbeat + BW'(1);
        end
    end

    assign axi_araddr_o  = r_raddr;
    assign axi_arlen_o   = 8'(LINE_WORDS - 1);
    assign axi_awaddr_o  = r_waddr;
    assign axi_awlen_o   = 8'(LINE_WORDS - 1);
    assign axi_wdata_o   = r_wbuf[{r_wbeat, 5'b0} +: 32];
    assign axi_wstrb_o   = 4'b1111;
    assign inst_rvalid_o = r_inst_rvalid;
    assign inst_rdata_o  = r_inst_rdata;
    assign data_rvalid_o = r_data_rvalid;
    assign data_rdata_o  = r_data_rdata;
    assign data_bvalid_o = r_bvalid;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: 4-word instance for arbitration, RAW and reset,
// 8-word instance for wide-line refill.
module tb_cache_axi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         inst_ren, inst_rvalid, data_ren, data_rvalid;
    logic [31:0]  inst_araddr, data_araddr, data_awaddr;
    logic [127:0] inst_rdata, data_rdata, data_wdata;
    logic         data_wen, data_bvalid;
    logic         arvalid, arready, rvalid, rlast, rready;
    logic [31:0]  araddr, rdata, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic         awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic [3:0]   wstrb;

    logic         e_inst_ren, e_inst_rvalid, e_data_rvalid, e_data_bvalid;
    logic [31:0]  e_inst_araddr;
    logic [255:0] e_inst_rdata, e_data_rdata;
    logic         e_arvalid, e_arready, e_rvalid, e_rready;
    logic [31:0]  e_araddr, e_rdata, e_awaddr, e_wdata;
    logic [7:0]   e_arlen, e_awlen;
    logic         e_awvalid, e_wvalid, e_wlast, e_bready;
    logic [3:0]   e_wstrb;

    cache_axi_arbiter #(.LINE_WORDS(4), .STARVE_MAX(2)) u_dut (
        .clk(clk), .rst(rst),
        .inst_ren_i(inst_ren), .inst_araddr_i(inst_araddr),
        .inst_rvalid_o(inst_rvalid), .inst_rdata_o(inst_rdata),
        .data_ren_i(data_ren), .data_araddr_i(data_araddr),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .data_wen_i(data_wen), .data_awaddr_i(data_awaddr),
        .data_wdata_i(data_wdata), .data_bvalid_o(data_bvalid),
        .axi_arvalid_o(arvalid), .axi_araddr_o(araddr),
        .axi_arlen_o(arlen), .axi_arready_i(arready),
        .axi_rvalid_i(rvalid), .axi_rdata_i(rdata),
        .axi_rlast_i(rlast), .axi_rready_o(rready),
        .axi_awvalid_o(awvalid), .axi_awaddr_o(awaddr),
        .axi_awlen_o(awlen), .axi_awready_i(awready),
        .axi_wvalid_o(wvalid), .axi_wdata_o(wdata),
        .axi_wlast_o(wlast), .axi_wstrb_o(wstrb),
        .axi_wready_i(wready), .axi_bvalid_i(bvalid),
        .axi_bready_o(bready)
    );

    cache_axi_arbiter #(.LINE_WORDS(8), .STARVE_MAX(2)) u_dut8 (
        .clk(clk), .rst(rst),
        .inst_ren_i(e_inst_ren), .inst_araddr_i(e_inst_araddr),
        .inst_rvalid_o(e_inst_rvalid), .inst_rdata_o(e_inst_rdata),
        .data_ren_i(1'b0), .data_araddr_i(32'h0),
        .data_rvalid_o(e_data_rvalid), .data_rdata_o(e_data_rdata),
        .data_wen_i(1'b0), .data_awaddr_i(32'h0),
        .data_wdata_i(256'h0), .data_bvalid_o(e_data_bvalid),
        .axi_arvalid_o(e_arvalid), .axi_araddr_o(e_araddr),
        .axi_arlen_o(e_arlen), .axi_arready_i(e_arready),
        .axi_rvalid_i(e_rvalid), .axi_rdata_i(e_rdata),
        .axi_rlast_i(1'b0), .axi_rready_o(e_rready),
        .axi_awvalid_o(e_awvalid), .axi_awaddr_o(e_awaddr),
        .axi_awlen_o(e_awlen), .axi_awready_i(1'b0),
        .axi_wvalid_o(e_wvalid), .axi_wdata_o(e_wdata),
        .axi_wlast_o(e_wlast), .axi_wstrb_o(e_wstrb),
        .axi_wready_i(1'b0), .axi_bvalid_i(1'b0),
        .axi_bready_o(e_bready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_accept(output logic [31:0] a, output logic [7:0] l);
        int n = 0;
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        chk("ar_wait", arvalid, 1);
        a = araddr;
        l = arlen;
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic r_beats(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1;
            rdata  = base + 32'(i);
            rlast  = (i == 3);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    logic [31:0] a;
    logic [7:0]  l;
    logic [31:0] exp_a [3];
    logic [31:0] wd [4];
    logic [3:0]  wl;
    int          got;
    logic        ar_seen;

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        inst_ren = 0; inst_araddr = 0; data_ren = 0; data_araddr = 0;
        data_wen = 0; data_awaddr = 0; data_wdata = 0;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0;
        e_inst_ren = 0; e_inst_araddr = 0; e_arready = 0;
        e_rvalid = 0; e_rdata = 0;
        exp_a[0] = 32'h4000_0000;
        exp_a[1] = 32'h4000_0000;
        exp_a[2] = 32'h1000_0100;

        rst = 0;
        tick();
        tick();
        chk("rst_ctl", {arvalid, rready, awvalid, wvalid, bready,
                        inst_rvalid, data_rvalid, data_bvalid}, 0);
        chk("rst_irdata", inst_rdata, 0);
        chk("rst_drdata", data_rdata, 0);
        rst = 1;
        tick();

        // icache refill, address alignment, single pulse
        inst_ren = 1; inst_araddr = 32'h1000_0014;
        ar_accept(a, l);
        chk("t1_araddr", a, 32'h1000_0010);
        chk("t1_arlen", l, 3);
        r_beats(32'hA0);
        chk("t1_rvalid", inst_rvalid, 1);
        chk("t1_rdata", inst_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_drdata", data_rdata, 0);
        tick();
        chk("t1_hold", {arvalid, inst_rvalid}, 0);
        inst_ren = 0;
        tick();

        // starvation: D, D, I
        rst = 0; tick(); rst = 1;
        inst_ren = 1; inst_araddr = 32'h1000_0100;
        data_ren = 1; data_araddr = 32'h4000_0000;
        for (int g = 0; g < 3; g++) begin
            ar_accept(a, l);
            chk("t2_grant", a, exp_a[g]);
            r_beats(32'(g * 16));
            chk("t2_pulse", {inst_rvalid, data_rvalid},
                (g == 2) ? 2'b10 : 2'b01);
        end
        chk("t2_irdata", inst_rdata, 128'h00000023_00000022_00000021_00000020);
        chk("t2_drdata", data_rdata, 128'h00000013_00000012_00000011_00000010);
        inst_ren = 0; data_ren = 0;
        tick();
        tick();

        // write-back with RAW-blocked dcache read and a passing icache read
        data_wen = 1; data_awaddr = 32'h2000_0040;
        data_wdata = 128'h000000D3_000000D2_000000D1_000000D0;
        tick();
        data_wdata = '1;
        data_ren = 1; data_araddr = 32'h2000_0048;
        inst_ren = 1; inst_araddr = 32'h1000_0200;
        chk("t3_aw", {awvalid, awaddr, awlen}, {1'b1, 32'h2000_0040, 8'd3});
        chk("t3_wstrb", wstrb, 4'hF);
        awready = 1;
        tick();
        awready = 0;
        chk("t3_iar", {arvalid, araddr}, {1'b1, 32'h1000_0200});
        ar_accept(a, l);
        r_beats(32'hB0);
        chk("t3_irvalid", inst_rvalid, 1);
        chk("t3_irdata", inst_rdata, 128'h000000B3_000000B2_000000B1_000000B0);
        inst_ren = 0;
        got = 0; wl = 0; ar_seen = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            wready = c[0];
            ar_seen = ar_seen | arvalid;
            if (wvalid && wready) begin
                wd[got] = wdata;
                wl[got] = wlast;
                got++;
            end
            tick();
        end
        wready = 0;
        for (int i = 0; i < 4; i++) chk("t3_wdata", wd[i], 32'hD0 + 32'(i));
        chk("t3_wlast", wl, 4'b1000);
        chk("t3_bready", bready, 1);
        bvalid = 1;
        ar_seen = ar_seen | arvalid;
        tick();
        bvalid = 0;
        ar_seen = ar_seen | arvalid;
        chk("t3_raw_block", ar_seen, 0);
        chk("t3_bpulse", data_bvalid, 1);
        tick();
        chk("t3_bhold", {data_bvalid, awvalid}, 0);
        chk("t3_dar", {arvalid, araddr}, {1'b1, 32'h2000_0040});
        data_wen = 0;
        ar_accept(a, l);
        r_beats(32'hC0);
        chk("t3_drdata", data_rdata, 128'h000000C3_000000C2_000000C1_000000C0);
        chk("t3_irkeep", inst_rdata, 128'h000000B3_000000B2_000000B1_000000B0);
        data_ren = 0;
        tick();
        tick();

        // reset during the third beat
        inst_ren = 1; inst_araddr = 32'h1000_0300;
        ar_accept(a, l);
        rvalid = 1; rdata = 32'hE0;
        tick();
        rdata = 32'hE1;
        tick();
        rdata = 32'hE2; rst = 0;
        tick();
        rst = 1; rvalid = 0;
        chk("t4_rst", {arvalid, rready, inst_rvalid, data_rvalid}, 0);
        chk("t4_irdata", inst_rdata, 0);
        tick();
        chk("t4_nopulse", inst_rvalid, 0);
        ar_accept(a, l);
        chk("t4_araddr", a, 32'h1000_0300);
        r_beats(32'hF0);
        chk("t4_rvalid", inst_rvalid, 1);
        chk("t4_rdata", inst_rdata, 128'h000000F3_000000F2_000000F1_000000F0);
        inst_ren = 0;
        tick();

        // 8-word line
        e_inst_ren = 1; e_inst_araddr = 32'h3000_001C;
        tick();
        chk("t5_ar", {e_arvalid, e_araddr, e_arlen}, {1'b1, 32'h3000_0000, 8'd7});
        e_arready = 1;
        tick();
        e_arready = 0;
        for (int i = 0; i < 8; i++) begin
            e_rvalid = 1;
            e_rdata = 32'h50 + 32'(i);
            tick();
        end
        e_rvalid = 0;
        chk("t5_rvalid", e_inst_rvalid, 1);
        chk("t5_rdata", e_inst_rdata,
            256'h00000057_00000056_00000055_00000054_00000053_00000052_00000051_00000050);
        e_inst_ren = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
